online_to_binary_converter: RTL and testbench
=============================================

// Module: online_to_binary_converter
// PURPOSE
//  Receiver end of the radix-4 online digit stream produced by multiply_add_1D and related online operators.
//  - Consumes one 3-bit signed digit per accepted beat, MSD first.
//  - Discards the operator's DELTA online-delay digits.
//  - Converts the next DIGITS digits to a two's-complement fixed-point word by on-the-fly conversion (no carry chain).
//  - Presents the word on a valid/ready output port.
//  - Sits between an online datapath and conventional (binary) consumers or the bench scoreboard.
// PARAMETERS
//  DIGITS  8  significant digits per frame; weight of converted digit j is 4^-j, j=0..DIGITS-1
//  DELTA   2  leading digits per frame discarded (online delay of the upstream operator); 0 allowed
//  W       2*DIGITS+1  (localparam) output width; 3 integer bits incl. sign, 2*(DIGITS-1) fraction bits
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous active-high reset
//  in_valid   in   1   digit present on in_digit this cycle
//  in_start   in   1   qualifies in_valid: this digit is index 0 of a new frame
//  in_digit   in   3   signed radix-4 digit, legal set {-3..3}; 3'b100 illegal
//  in_ready   out  1   converter accepts a digit this cycle
//  out_valid  out  1   out_data holds a completed conversion
//  out_ready  in   1   consumer takes out_data when out_valid & out_ready
//  out_data   out  W   signed result = sum d_j*4^-j, scaled by 4^(DIGITS-1)
//  err        out  1   sticky: illegal digit seen in current/last frame
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: state IDLE, cnt=0, Q=0, QM=all-ones, in_ready=1, out_valid=0, out_data=0, err=0.
//    Reset wins over every other event, including mid-frame or with out_valid pending; the partial frame is lost.
//  - Accept = in_valid & in_ready. in_ready = (state != DONE). No combinational path from out_ready to in_ready.
//  - Beats with in_valid=0 are gaps; state and counters hold.
//  - States:
//    IDLE   : accept with in_start=1 -> index 0 consumed, cnt=1, err cleared.
//             Digit 0 goes to SKIP (DELTA>0) or is converted (DELTA=0).
//             Accepts without in_start are dropped.
//    SKIP   : each accept increments cnt; digit discarded. cnt reaches DELTA -> CONVERT.
//    CONVERT: each accept updates Q/QM and increments cnt.
//             Accept of digit index DELTA+DIGITS-1 -> DONE.
//             Next cycle: out_valid=1, out_data=Q_final.
//    DONE   : out_data/out_valid held stable until out_ready=1; handshake cycle -> IDLE.
//             out_valid=0 next cycle; out_data keeps its last value.
//  - in_start=1 on an accept in SKIP or CONVERT aborts the frame. That digit becomes index 0; Q/QM/cnt/err reinitialise as in IDLE.
//  - On-the-fly conversion, d = in_digit signed, Q/QM W-bit, shift = x4 (append 2 bits):
//      Q'  = (d>=0) ? {Q,2'(d)}      : {QM,2'(4+d)}
//      QM' = (d>0)  ? {Q,2'(d-1)}    : {QM,2'(3+d)}
//    Invariant QM = Q-1 after each step; the top bits discarded by the shift are sign copies.
//  - Range: |result| <= 4-4^-(DIGITS-1); always representable in W bits, no overflow.
//  - Illegal digit 3'b100: treated as -3 and sets err. err is cleared only by reset or a new frame start.
//  - Latency: out_valid rises exactly 1 cycle after the last significant digit is accepted.
//    Total frame = DELTA+DIGITS accepts.
// TESTING  (DIGITS=8, DELTA=2, W=17)
//  1. Frame 0,0,0,0,1,0,0,0,0,0 (start on first) -> 2 skips; result 4^-2 -> out_data=17'h00400, err=0,
//     out_valid 1 cycle after 10th accept.
//  2. Frame x,x,1,-1,0,0,0,0,0,0 -> 0.75 -> out_data=17'h03000.
//     Same frame with random in_valid gaps -> identical result and cycle count in accepts.
//  3. Two skips then eight digits of 3 -> 17'h0FFFF; eight digits of -3 -> 17'h10001.
//     Extremes; no overflow.
//  4. out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready=0, offered digits not consumed.
//     out_ready=1 -> handshake, IDLE, next frame converts correctly.
//  5. in_start reasserted at digit index 5 -> frame restarts.
//     Result reflects only the new frame; err cleared.
//     Digit 3'b100 inside a frame -> err=1 and result computed with -3.
//  6. rst pulsed mid-CONVERT and again during DONE -> all outputs at reset values next cycle.
//     Following frame converts correctly.

Source files
------------

// File: rtl/online_to_binary_converter_if.sv
// Bundles the digit-stream input and the binary-word output of the
// online-to-binary converter, plus a read-only view of the FSM state.
interface online_to_binary_converter_if #(
    parameter int DIGITS = 8
) ();
    localparam int W = 2 * DIGITS + 1;

    // Handshake rule for both ports: a transfer happens on a rising clk edge
    // where valid and ready are both high. The producer holds its payload
    // stable while valid is high and ready is low; ready never depends
    // combinationally on the opposite port's valid/ready.
    logic         in_valid;
    logic         in_start;
    logic [2:0]   in_digit;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         err;
    logic [1:0]   dbg_state;

    // Digit producer / word consumer side
    modport master (
        output in_valid, in_start, in_digit, out_ready,
        input  in_ready, out_valid, out_data, err, dbg_state
    );

    // Converter side
    modport slave (
        input  in_valid, in_start, in_digit, out_ready,
        output in_ready, out_valid, out_data, err, dbg_state
    );
endinterface

// File: rtl/online_to_binary_converter.sv
// Receives an MSD-first radix-4 signed-digit stream, drops the upstream
// online-delay digits, and converts the remaining digits to a two's-complement
// word with on-the-fly conversion (Q / QM = Q-1 kept in parallel).
module online_to_binary_converter #(
    parameter int DIGITS = 8,
    parameter int DELTA  = 2
) (
    input logic clk,
    input logic rst,
    online_to_binary_converter_if.slave bus
);
    localparam int W     = 2 * DIGITS + 1;
    localparam int FRAME = DELTA + DIGITS;
    localparam int CW    = $clog2(FRAME + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  q, q_n, qm, qm_n;
    logic [W-1:0]  data_r, data_n;
    logic          err_r, err_n;

    logic          accept;
    logic          new_frame;
    logic          illegal;
    logic [2:0]    d;
    logic [2:0]    dm1;
    logic [W-1:0]  q_base, qm_base;
    logic [W-1:0]  q_step, qm_step;
    logic [CW-1:0] idx;
    logic          err_base;

    // Digit decode and one conversion step. A frame start rebases the step on
    // the reset values so a restart mid-frame behaves exactly like IDLE.
    // The low two bits of 4+d and d agree (likewise 3+d and d-1), so only the
    // choice between Q and QM depends on the digit sign.
    always_comb begin
        illegal   = (bus.in_digit == 3'b100);
        d         = illegal ? 3'b101 : bus.in_digit;
        dm1       = d - 3'd1;
        accept    = bus.in_valid && (state != DONE);
        new_frame = accept && bus.in_start;
        q_base    = new_frame ? '0 : q;
        qm_base   = new_frame ? '1 : qm;
        idx       = new_frame ? '0 : cnt;
        err_base  = new_frame ? 1'b0 : err_r;
        q_step    = d[2] ? {qm_base[W-3:0], d[1:0]} : {q_base[W-3:0], d[1:0]};
        qm_step   = (!d[2] && (d != 3'd0)) ? {q_base[W-3:0], dm1[1:0]}
                                           : {qm_base[W-3:0], dm1[1:0]};
    end

    // Next-state logic: frame sequencing, digit indexing and result capture.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        qm_n    = qm;
        data_n  = data_r;
        err_n   = err_r;
        if (state == DONE) begin
            if (bus.out_ready) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else if (accept && (new_frame || (state != IDLE))) begin
            cnt_n = idx + 1'b1;
            err_n = err_base | illegal;
            if (idx >= CW'(DELTA)) begin
                q_n  = q_step;
                qm_n = qm_step;
            end else begin
                q_n  = q_base;
                qm_n = qm_base;
            end
            if (idx == CW'(FRAME - 1)) begin
                state_n = DONE;
                data_n  = q_step;
            end else if (cnt_n >= CW'(DELTA)) begin
                state_n = CONVERT;
            end else begin
                state_n = SKIP;
            end
        end
    end

    // State register; reset overrides any frame in flight or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            q      <= '0;
            qm     <= '1;
            data_r <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            q      <= q_n;
            qm     <= qm_n;
            data_r <= data_n;
            err_r  <= err_n;
        end
    end

    assign bus.in_ready  = (state != DONE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = data_r;
    assign bus.err       = err_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_online_to_binary_converter.sv
// Directed bench for online_to_binary_converter (DIGITS=8, DELTA=2, W=17).
module tb_online_to_binary_converter;
    localparam int DIGITS = 8;
    localparam int DELTA  = 2;
    localparam int W      = 2 * DIGITS + 1;
    localparam int FRAME  = DELTA + DIGITS;

    typedef struct {
        string        name;
        int           d[FRAME];
        logic [W-1:0] exp;
        logic         exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [W-1:0] exp_q[$];
    vec_t vt[8];

    online_to_binary_converter_if #(.DIGITS(DIGITS)) bus ();

    online_to_binary_converter #(.DIGITS(DIGITS), .DELTA(DELTA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [2:0] enc(input int v);
        logic [2:0] r;
        if (v == -4) r = 3'b100;
        else r = 3'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
    endtask

    // driver: offer one digit and wait (bounded) until it is accepted
    task automatic send_digit(input logic start, input int v);
        bit done;
        bus.in_valid = 1'b1;
        bus.in_start = start;
        bus.in_digit = enc(v);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.in_ready) done = 1'b1;
            tick();
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
    endtask

    // driver + scoreboard: full frame, result checked right after last accept
    task automatic send_frame(input int d[FRAME], input logic [W-1:0] exp,
                              input logic exp_err, input bit gaps, input string name);
        logic [W-1:0] e;
        exp_q.push_back(exp);
        for (int i = 0; i < FRAME; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) tick();
            end
            send_digit(i == 0, d[i]);
            if (i == FRAME - 2) check({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        end
        e = exp_q.pop_front();
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_data"}, 32'(bus.out_data), 32'(e));
        check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    endtask

    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, "_hs_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int f_a[FRAME];
        int f_b[FRAME];
        logic [W-1:0] held;

        n_checks = 0;
        n_pass   = 0;
        bus.in_valid  = 1'b0;
        bus.in_start  = 1'b0;
        bus.in_digit  = 3'd0;
        bus.out_ready = 1'b0;

        vt[0] = '{"single",   '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0}, 17'h00400, 1'b0};
        vt[1] = '{"p75",      '{2, -1, 1, -1, 0, 0, 0, 0, 0, 0}, 17'h03000, 1'b0};
        vt[2] = '{"max",      '{0, 0, 3, 3, 3, 3, 3, 3, 3, 3}, 17'h0FFFF, 1'b0};
        vt[3] = '{"min",      '{0, 0, -3, -3, -3, -3, -3, -3, -3, -3}, 17'h10001, 1'b0};
        vt[4] = '{"illegal",  '{0, 0, 0, -4, 0, 0, 0, 0, 0, 0}, 17'h1D000, 1'b1};
        vt[5] = '{"lsd_neg",  '{1, 1, 2, 0, 0, 0, 0, 0, 0, -1}, 17'h07FFF, 1'b0};
        vt[6] = '{"neg_q",    '{0, 0, -1, 0, 0, 0, 0, 0, 0, 0}, 17'h1C000, 1'b0};
        vt[7] = '{"mixed",    '{3, 3, 1, 2, 3, 0, -2, 1, -3, 2}, 17'h06B86, 1'b0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        // table: every vector without gaps, then with random gaps
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                send_frame(vt[i].d, vt[i].exp, vt[i].exp_err, p == 1, vt[i].name);
                handshake(vt[i].name);
            end
        end

        // back-pressure: result held, offered digits refused
        send_frame(vt[0].d, vt[0].exp, 1'b0, 1'b0, "bp");
        held = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_start = 1'b1;
        bus.in_digit = 3'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_data", 32'(bus.out_data), 32'(vt[0].exp));
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        handshake("bp");
        check("bp_data_kept", 32'(bus.out_data), 32'(held));
        send_frame(vt[1].d, vt[1].exp, 1'b0, 1'b0, "bp_next");
        handshake("bp_next");

        // non-start digits in IDLE are dropped
        bus.in_valid = 1'b1;
        bus.in_start = 1'b0;
        bus.in_digit = 3'd3;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("idle_drop_state", 32'(bus.dbg_state), 32'd0);
        send_frame(vt[0].d, vt[0].exp, 1'b0, 1'b0, "after_drop");
        handshake("after_drop");

        // restart at index 5 after an illegal digit; new frame is clean
        f_a = '{0, 0, -4, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            send_digit(i == 0, f_a[i]);
            if (i == 2) check("restart_err_set", 32'(bus.err), 32'd1);
        end
        send_frame(vt[1].d, vt[1].exp, 1'b0, 1'b0, "restart");
        handshake("restart");

        // reset mid-CONVERT
        f_b = '{1, 1, 3, 3, 3, 0, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) send_digit(i == 0, f_b[i]);
        pulse_reset();
        check_reset_values("rst_conv");
        send_frame(vt[2].d, vt[2].exp, 1'b0, 1'b0, "rst_conv_next");

        // reset while DONE with result pending
        pulse_reset();
        check_reset_values("rst_done");
        send_frame(vt[7].d, vt[7].exp, 1'b0, 1'b0, "rst_done_next");
        handshake("rst_done_next");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
